// File: rtl/xlr8_evt_fifo.sv
// Event FIFO from user logic to the AVR, drained and monitored over the DM register bus.
// Optional threshold interrupt register enabled by defining XLR8_EVT_FIFO_IRQ_EN.
module xlr8_evt_fifo #(
    parameter logic [7:0]  DATA_ADDR   = 8'd0,
    parameter logic [7:0]  STATUS_ADDR = 8'd1,
    parameter logic [7:0]  CTRL_ADDR   = 8'd2,
    parameter logic [7:0]  THRESH_ADDR = 8'd3,
    parameter int unsigned DEPTH_LOG2  = 4,
    parameter int unsigned WIDTH       = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clken,
    input  logic [7:0]       dbus_in,
    output logic [7:0]       dbus_out,
    output logic             io_out_en,
    input  logic [7:0]       ramadr,
    input  logic             ramre,
    input  logic             ramwe,
    input  logic             dm_sel,
    input  logic             evt_valid,
    input  logic [WIDTH-1:0] evt_data,
    output logic             evt_ready,
    output logic             irq
);

    localparam int unsigned CW = DEPTH_LOG2 + 1;
    localparam logic [CW-1:0] DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [WIDTH-1:0]      mem [0:(1 << DEPTH_LOG2) - 1];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [CW-1:0]         count;
    logic [CW-1:0]         count_next;
    logic                  overflow;
    logic                  underflow;

    logic data_sel, status_sel, ctrl_sel;
    logic full, empty;
    logic ctrl_wr, flush, do_pop, do_push, ovf_set, udf_set;
    logic [7:0] head_word;
    logic [4:0] count5;
    logic unused_bits;

    assign data_sel   = dm_sel && (ramadr == DATA_ADDR);
    assign status_sel = dm_sel && (ramadr == STATUS_ADDR);
    assign ctrl_sel   = dm_sel && (ramadr == CTRL_ADDR);
    assign full       = (count == DEPTH_CNT);
    assign empty      = (count == '0);
    assign evt_ready  = !full;
    assign unused_bits = ^dbus_in[7:3];

    // Flush dominates: a same-cycle push is discarded and cannot raise overflow.
    always_comb begin
        ctrl_wr = clken && ctrl_sel && ramwe;
        flush   = ctrl_wr && dbus_in[0];
        do_pop  = clken && data_sel && ramre && !empty;
        udf_set = clken && data_sel && ramre && empty;
        do_push = evt_valid && (!full || do_pop) && !flush;
        ovf_set = evt_valid && full && !do_pop && !flush;
        count_next = count;
        if (flush)
            count_next = '0;
        else if (do_push && !do_pop)
            count_next = count + 1'b1;
        else if (do_pop && !do_push)
            count_next = count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            count     <= count_next;
            overflow  <= ovf_set || (overflow && !(ctrl_wr && dbus_in[1]));
            underflow <= udf_set || (underflow && !(ctrl_wr && dbus_in[2]));
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + 1'b1;
                if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rstn && do_push)
            mem[wr_ptr] <= evt_data;
    end

`ifdef XLR8_EVT_FIFO_IRQ_EN
    logic       thresh_sel;
    logic [4:0] thresh;
    logic [4:0] count_next5;

    assign thresh_sel = dm_sel && (ramadr == THRESH_ADDR);

    always_comb begin
        count_next5 = '0;
        count_next5[CW-1:0] = count_next;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            thresh <= 5'd1;
            irq    <= 1'b0;
        end else begin
            irq <= (count_next5 >= thresh) && (thresh != '0);
            if (clken && thresh_sel && ramwe)
                thresh <= dbus_in[4:0];
        end
    end
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        head_word = '0;
        if (!empty)
            head_word[WIDTH-1:0] = mem[rd_ptr];
        count5 = '0;
        count5[CW-1:0] = count;
        dbus_out  = '0;
        io_out_en = 1'b0;
        if (data_sel && ramre) begin
            dbus_out  = head_word;
            io_out_en = 1'b1;
        end else if (status_sel && ramre) begin
            dbus_out  = {overflow, underflow, full, count5};
            io_out_en = 1'b1;
        end
`ifdef XLR8_EVT_FIFO_IRQ_EN
        else if (thresh_sel && ramre) begin
            dbus_out  = {3'b000, thresh};
            io_out_en = 1'b1;
        end
`endif
    end

endmodule
